// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_pkg
//  Purpose  : Shared types and constants for the TMR fault-injection block.
//             Holds the campaign state encoding, the lane encoding, the LFSR
//             feedback mask and the default LFSR seed, plus two small helpers.
//  Revision : 1.0  initial release
// ============================================================================
package tmr_pkg;

    // Campaign sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INJECT = 3'd1,
        ST_CHECK  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } tmr_state_t;

    // Replica lane identifiers
    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2
    } tmr_lane_t;

    // Fibonacci feedback taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] c_lfsr_taps    = 16'hB400;
    localparam logic [15:0] c_default_seed = 16'hACE1;

    // Two random bits pick a lane; the unused code 3 folds onto lane A.
    function automatic tmr_lane_t lane_from_bits(input logic [1:0] b);
        return (b == 2'd3) ? LANE_A : tmr_lane_t'(b);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_lfsr16
//  Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11), left-shifting, with
//             the feedback bit entering at bit 0. Loads seed on reset and
//             advances one step per cycle while en is high.
//  Ports    : clk   - clock
//             rst   - synchronous active-high reset (loads seed)
//             en    - advance enable
//             seed  - reset value, must be non-zero
//             state - current register contents
//  Revision : 1.0  initial release
// ============================================================================
module tmr_lfsr16
    import tmr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] r_state;
    logic        w_feedback;

    assign w_feedback = ^(r_state & c_lfsr_taps);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= seed;
        end else if (en) begin
            r_state <= {r_state[14:0], w_feedback};
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/tmr_fault_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_fault_injector
//  Purpose  : Drives three replica lanes into an external TMR voter, flips a
//             single pseudo-random bit in one pseudo-random lane per
//             injection, and scores the voter's response.
//             Per injection: INJECT (lane corrupted on exit) -> CHECK (voter
//             sampled, lanes restored on exit) -> GAP (voter must be quiet).
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start                 - begin a campaign (honoured in IDLE only)
//             num_faults            - number of injections, latched on start
//             data_in               - golden value, latched on start
//             lane_a/lane_b/lane_c  - registered replicas to the voter
//             voter_out, voter_err  - voter result and disagreement flag
//             busy                  - high during INJECT, CHECK and GAP
//             done                  - one-cycle pulse ending a campaign
//             fault_lane            - lane of the latest injection (0=a,1=b,2=c)
//             mismatch_count        - CHECK cycles with voter_out != golden
//             miss_count            - CHECK cycles with voter_err low
//             false_err_count       - GAP cycles with voter_err high
//  Revision : 1.0  initial release
// ============================================================================
module tmr_fault_injector
    import tmr_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = c_default_seed
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_faults,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] lane_a,
    output logic [WIDTH-1:0] lane_b,
    output logic [WIDTH-1:0] lane_c,
    input  logic [WIDTH-1:0] voter_out,
    input  logic             voter_err,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fault_lane,
    output logic [15:0]      mismatch_count,
    output logic [15:0]      miss_count,
    output logic [15:0]      false_err_count
);

    localparam int c_bit_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tmr_state_t       r_state;
    logic [WIDTH-1:0] r_data_q;
    logic [15:0]      r_remaining;
    logic [WIDTH-1:0] r_lane_a;
    logic [WIDTH-1:0] r_lane_b;
    logic [WIDTH-1:0] r_lane_c;
    tmr_lane_t        r_fault_lane;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_mismatch;
    logic [15:0]      r_miss;
    logic [15:0]      r_false_err;

    logic [15:0]        w_lfsr;
    logic               w_lfsr_en;
    tmr_lane_t          w_lane;
    logic [c_bit_w-1:0] w_bit;
    logic [WIDTH-1:0]   w_flip;
    logic               w_unused_lfsr;

    // The LFSR steps on the edge that leaves INJECT, so each injection is
    // chosen from the value held during its INJECT cycle; the very first
    // injection after reset therefore uses SEED itself.
    assign w_lfsr_en = (r_state == ST_INJECT);

    tmr_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_lfsr_en),
        .seed  (SEED),
        .state (w_lfsr)
    );

    // WIDTH is a power of two, so "mod WIDTH" is just the low bits of [15:8].
    assign w_lane        = lane_from_bits(w_lfsr[1:0]);
    assign w_bit         = w_lfsr[8 +: c_bit_w];
    assign w_flip        = {{(WIDTH-1){1'b0}}, 1'b1} << w_bit;
    assign w_unused_lfsr = ^w_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data_q     <= '0;
            r_remaining  <= '0;
            r_lane_a     <= '0;
            r_lane_b     <= '0;
            r_lane_c     <= '0;
            r_fault_lane <= LANE_A;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mismatch   <= '0;
            r_miss       <= '0;
            r_false_err  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_data_q    <= data_in;
                        r_remaining <= num_faults;
                        r_mismatch  <= '0;
                        r_miss      <= '0;
                        r_false_err <= '0;
                        // Lanes track the new golden value straight away so
                        // none of them differs from it outside CHECK.
                        r_lane_a    <= data_in;
                        r_lane_b    <= data_in;
                        r_lane_c    <= data_in;
                        if (num_faults == 16'd0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_INJECT;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_INJECT: begin
                    r_lane_a     <= (w_lane == LANE_A) ? (r_data_q ^ w_flip) : r_data_q;
                    r_lane_b     <= (w_lane == LANE_B) ? (r_data_q ^ w_flip) : r_data_q;
                    r_lane_c     <= (w_lane == LANE_C) ? (r_data_q ^ w_flip) : r_data_q;
                    r_fault_lane <= w_lane;
                    r_state      <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (voter_out != r_data_q) begin
                        r_mismatch <= sat_inc(r_mismatch);
                    end
                    if (!voter_err) begin
                        r_miss <= sat_inc(r_miss);
                    end
                    r_lane_a <= r_data_q;
                    r_lane_b <= r_data_q;
                    r_lane_c <= r_data_q;
                    r_state  <= ST_GAP;
                end

                ST_GAP: begin
                    if (voter_err) begin
                        r_false_err <= sat_inc(r_false_err);
                    end
                    r_remaining <= r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_INJECT;
                    end
                end

                ST_DONE: begin
                    // done is registered off DONE, so it shows in the cycle
                    // after DONE: 3N+1 cycles after the accepting edge.
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lane_a          = r_lane_a;
    assign lane_b          = r_lane_b;
    assign lane_c          = r_lane_c;
    assign busy            = r_busy;
    assign done            = r_done;
    assign fault_lane      = r_fault_lane;
    assign mismatch_count  = r_mismatch;
    assign miss_count      = r_miss;
    assign false_err_count = r_false_err;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_fault_injector
//  Purpose  : Self-checking bench for tmr_fault_injector. A behavioural
//             voter (with selectable stuck modes) closes the loop; an
//             independent LFSR model predicts every injection; a scoreboard
//             queue holds the expected counters of each campaign until its
//             done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmr_fault_injector;

    localparam int          WIDTH = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [15:0]      num_faults;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] lane_a, lane_b, lane_c;
    logic [WIDTH-1:0] voter_out;
    logic             voter_err;
    logic             busy, done;
    logic [1:0]       fault_lane;
    logic [15:0]      mismatch_count, miss_count, false_err_count;

    tmr_fault_injector #(.WIDTH(WIDTH), .SEED(SEED)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_faults      (num_faults),
        .data_in         (data_in),
        .lane_a          (lane_a),
        .lane_b          (lane_b),
        .lane_c          (lane_c),
        .voter_out       (voter_out),
        .voter_err       (voter_err),
        .busy            (busy),
        .done            (done),
        .fault_lane      (fault_lane),
        .mismatch_count  (mismatch_count),
        .miss_count      (miss_count),
        .false_err_count (false_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Voter modes: 0 ideal, 1 err stuck 0, 2 out stuck 0, 3 err stuck 1
    int               vmode;
    logic [WIDTH-1:0] w_maj;
    logic             w_dis;
    assign w_maj = (lane_a & lane_b) | (lane_b & lane_c) | (lane_a & lane_c);
    assign w_dis = (lane_a != lane_b) || (lane_b != lane_c);
    always_comb begin
        voter_out = (vmode == 2) ? '0 : w_maj;
        voter_err = (vmode == 1) ? 1'b0 : (vmode == 3) ? 1'b1 : w_dis;
    end

    typedef struct {
        logic [15:0] mm;
        logic [15:0] miss;
        logic [15:0] fe;
    } exp_t;

    typedef struct {
        int               mode;
        logic [WIDTH-1:0] data;
        int               n;
        logic [15:0]      mm;
        logic [15:0]      miss;
        logic [15:0]      fe;
        bit               poke;
    } vec_t;

    exp_t        sb[$];
    logic [1:0]  dut_log[$];
    logic [1:0]  abort_log[$];
    logic [15:0] m_lfsr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [1:0] model_lane(input logic [15:0] s);
        return (s[1:0] == 2'd3) ? 2'd0 : s[1:0];
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"},  {31'd0, busy}, 32'd0);
        chk({tag, " done"},  {31'd0, done}, 32'd0);
        chk({tag, " lanes"}, {8'd0, lane_a, lane_b, lane_c}, 32'd0);
        chk({tag, " fault_lane"}, {30'd0, fault_lane}, 32'd0);
        chk({tag, " mismatch"}, {16'd0, mismatch_count}, 32'd0);
        chk({tag, " miss"}, {16'd0, miss_count}, 32'd0);
        chk({tag, " false_err"}, {16'd0, false_err_count}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;   // reset must win over start
        @(negedge clk);
        rst    = 1'b0;
        start  = 1'b0;
        m_lfsr = SEED;
        sb.delete();
        chk_idle_zero("reset");
    endtask

    // One full campaign, checked every cycle from the accepting edge (k=0)
    // until one cycle past the done pulse.
    task automatic run_campaign(input string tag, input vec_t v);
        logic [WIDTH-1:0] ea, eb, ec, flip;
        logic [1:0]       l;
        exp_t             e;
        @(negedge clk);
        vmode      = v.mode;
        start      = 1'b1;
        data_in    = v.data;
        num_faults = 16'(v.n);
        sb.push_back('{mm: v.mm, miss: v.miss, fe: v.fe});
        for (int k = 0; k <= 3 * v.n + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                data_in    = ~v.data;          // must not disturb the campaign
                num_faults = 16'(v.n + 3);
            end
            ea = v.data; eb = v.data; ec = v.data;
            if (k < 3 * v.n && (k % 3) == 1) begin
                l    = model_lane(m_lfsr);
                flip = WIDTH'(1) << (m_lfsr[15:8] % WIDTH);
                if (l == 2'd0) ea = ea ^ flip;
                if (l == 2'd1) eb = eb ^ flip;
                if (l == 2'd2) ec = ec ^ flip;
                chk($sformatf("%s k%0d fault_lane", tag, k), {30'd0, fault_lane}, {30'd0, l});
                dut_log.push_back(fault_lane);
                m_lfsr = lfsr_next(m_lfsr);
            end
            chk($sformatf("%s k%0d lanes", tag, k), {8'd0, lane_a, lane_b, lane_c}, {8'd0, ea, eb, ec});
            chk($sformatf("%s k%0d busy", tag, k), {31'd0, busy}, {31'd0, (k < 3 * v.n)});
            chk($sformatf("%s k%0d done", tag, k), {31'd0, done}, {31'd0, (k == 3 * v.n + 1)});
            if (done) begin
                if (sb.size() == 0) begin
                    chk({tag, " scoreboard underflow"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " mismatch"}, {16'd0, mismatch_count}, {16'd0, e.mm});
                    chk({tag, " miss"}, {16'd0, miss_count}, {16'd0, e.miss});
                    chk({tag, " false_err"}, {16'd0, false_err_count}, {16'd0, e.fe});
                end
            end
            start = v.poke && (k == 2);   // a start mid-campaign is ignored
        end
        chk({tag, " scoreboard drained"}, sb.size(), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        vec_t ab;
        rst = 1'b1; start = 1'b0; num_faults = '0; data_in = '0; vmode = 0;
        tbl[0] = '{mode: 0, data: 8'hA5, n: 4,  mm: 16'd0, miss: 16'd0, fe: 16'd0, poke: 1'b0};
        tbl[1] = '{mode: 1, data: 8'h3C, n: 5,  mm: 16'd0, miss: 16'd5, fe: 16'd0, poke: 1'b1};
        tbl[2] = '{mode: 2, data: 8'hA5, n: 3,  mm: 16'd3, miss: 16'd0, fe: 16'd0, poke: 1'b0};
        tbl[3] = '{mode: 3, data: 8'h5A, n: 2,  mm: 16'd0, miss: 16'd0, fe: 16'd2, poke: 1'b0};
        tbl[4] = '{mode: 0, data: 8'hFF, n: 0,  mm: 16'd0, miss: 16'd0, fe: 16'd0, poke: 1'b0};
        tbl[5] = '{mode: 0, data: 8'h01, n: 7,  mm: 16'd0, miss: 16'd0, fe: 16'd0, poke: 1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) run_campaign($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a campaign, then replay from SEED.
        do_reset();
        vmode = 1;
        @(negedge clk);
        start = 1'b1; data_in = 8'h96; num_faults = 16'd10;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if ((k % 3) == 1) begin
                chk($sformatf("abort k%0d fault_lane", k), {30'd0, fault_lane}, {30'd0, model_lane(m_lfsr)});
                abort_log.push_back(fault_lane);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        chk("abort miss before reset", {16'd0, miss_count}, 32'd1);
        chk("abort busy before reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("abort");
        @(negedge clk);
        chk("abort stays idle", {31'd0, busy}, 32'd0);

        m_lfsr = SEED;
        dut_log.delete();
        ab = '{mode: 0, data: 8'h96, n: 10, mm: 16'd0, miss: 16'd0, fe: 16'd0, poke: 1'b0};
        run_campaign("replay", ab);
        for (int i = 0; i < 2; i++) begin
            if (i < abort_log.size() && i < dut_log.size())
                chk($sformatf("replay seq %0d", i), {30'd0, dut_log[i]}, {30'd0, abort_log[i]});
            else
                chk($sformatf("replay seq %0d missing", i), 32'd1, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tmr_fault_injector.md
TMR_FAULT_INJECTOR -- requirements
Module: tmr_fault_injector

Interface
REQ-001 Parameter WIDTH, default 8: lane data width; SHALL be a power of two, 2..32.
REQ-002 Parameter SEED, default 16'hACE1: LFSR reset value; SHALL be non-zero.
REQ-003 Port clk  input  1  sole clock; all logic on posedge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  begin campaign; sampled only in IDLE.
REQ-006 Port num_faults  input  16  injections per campaign; latched on accepted start.
REQ-007 Port data_in  input  WIDTH  golden value; latched on accepted start.
REQ-008 Port lane_a / lane_b / lane_c  output  WIDTH each  registered replicas fed to the voter under test.
REQ-009 Port voter_out  input  WIDTH  voted value from the voter under test.
REQ-010 Port voter_err  input  1  disagreement flag from the voter under test.
REQ-011 Port busy  output  1  high in INJECT, CHECK and GAP.
REQ-012 Port done  output  1  one-cycle pulse at campaign end.
REQ-013 Port fault_lane  output  2  lane of the current injection: 0=a, 1=b, 2=c.
REQ-014 Ports mismatch_count, miss_count, false_err_count  output  16 each  error counters.

Function
REQ-015 FSM states: IDLE, INJECT, CHECK, GAP, DONE.
REQ-016 IDLE: when start=1, SHALL latch data_in to data_q and num_faults to remaining, clear all three counters, and go to INJECT; if num_faults=0, SHALL go to DONE instead.
REQ-017 INJECT (1 cycle): SHALL advance the LFSR once.
- lane = lfsr[1:0], with 3 mapped to 0.
- bit = lfsr[15:8] mod WIDTH.
- On the exiting edge, the selected lane register loads data_q ^ (1<<bit); the other two load data_q; fault_lane loads lane.
REQ-018 CHECK (1 cycle): SHALL sample the voter inputs.
- voter_out != data_q: mismatch_count +1.
- voter_err=0: miss_count +1.
- On the exiting edge, all lanes load data_q.
REQ-019 GAP (1 cycle): voter_err=1 SHALL increment false_err_count; remaining decrements; next state is DONE if remaining becomes 0, else INJECT.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; lanes hold data_q and counters hold their values until the next accepted start.
REQ-021 Latency: done asserted 3N+1 cycles after the accepted start edge (N=num_faults); N=0 gives 1 cycle.
REQ-022 start SHALL be ignored outside IDLE; data_in and num_faults changes during a campaign SHALL have no effect.
REQ-023 Counters SHALL saturate at 16'hFFFF.
REQ-024 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance only in INJECT.
REQ-025 Exactly one lane, with exactly one bit flipped, SHALL differ from data_q during any CHECK cycle; no lane SHALL differ outside CHECK.

Reset
REQ-026 On rst=1 at a clock edge, regardless of state, the block SHALL:
- go to IDLE;
- set lanes, data_q, remaining, counters and fault_lane to 0 and busy, done to 0;
- load the LFSR with SEED.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Shared package tmr_pkg SHALL hold:
- state enum;
- lane enum;
- LFSR tap constant;
- default SEED.
REQ-029 The LFSR SHALL be a sub-module tmr_lfsr16 with ports clk, rst, en, seed and state.

Verification
REQ-030 Ideal behavioural voter, data_in=8'hA5, N=4, start pulse -> done 13 cycles later; all counters 0; each CHECK shows exactly one flipped bit on fault_lane.
REQ-031 voter_err tied 0, N=5 -> miss_count=5, mismatch_count=0, false_err_count=0.
REQ-032 voter_out stuck at 8'h00, data_in=8'hA5, N=3 -> mismatch_count=3.
REQ-033 voter_err tied 1, N=2 -> false_err_count=2, miss_count=0.
REQ-034 N=0 -> done 1 cycle after start, busy never high; a start during busy is ignored (done timing unchanged).
REQ-035 rst asserted in CHECK of a N=10 run -> next cycle IDLE, lanes 0, counters 0; a fresh start reproduces the identical fault_lane sequence from SEED.
